// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard/flush sequencer.
package pipe_ctrl_pkg;

  // Width of the tuse/tnew cycle counts carried with each instruction.
  localparam int T_W = 2;

  // A tuse of 3 marks a source register the instruction never reads.
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  // Next-PC source select.
  localparam logic [1:0] PC_SEQ = 2'b00;  // sequential / branch target
  localparam logic [1:0] PC_EXC = 2'b01;  // exception handler 0x4180
  localparam logic [1:0] PC_EPC = 2'b10;  // return through EPC

  // Default MDU occupancy after a start.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: loads the operation latency on an accepted
// start and counts down to zero; busy covers the start cycle as well.
module md_busy_timer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  input  logic is_div,
  input  logic flush,
  output logic busy
);

  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  // A flushed start never loads; a running count is left to finish.
  always_comb begin
    timer_d = timer_q;
    if (start && !flush) begin
      timer_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (timer_q != '0) begin
      timer_d = timer_q - CNT_W'(1);
    end
  end

  // Timer register; reset clears any in-flight operation immediately.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Busy in the start cycle and every cycle the count is non-zero; held low in reset.
  always_comb begin
    busy = res && ((timer_q != '0) || start);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage pipeline: data/MDU stall detection,
// exception/ERET flush, next-PC select and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [T_W-1:0]    D_tuse_rs,
  input  logic [T_W-1:0]    D_tuse_rt,
  input  logic              D_is_md,
  input  logic [4:0]        E_dst,
  input  logic [4:0]        M_dst,
  input  logic [T_W-1:0]    E_tnew,
  input  logic [T_W-1:0]    M_tnew,
  input  logic              E_md_start,
  input  logic              E_md_div,
  input  logic              M_exc_req,
  input  logic              M_eret,
  input  logic              perf_clr,
  output logic              F_WE,
  output logic              D_WE,
  output logic              D_clr,
  output logic              E_clr,
  output logic              M_clr,
  output logic              E_keep_pc,
  output logic [1:0]        pc_sel,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;
  logic flush;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  // MDU occupancy tracking.
  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk    (clk),
    .res    (res),
    .start  (E_md_start),
    .is_div (E_md_div),
    .flush  (flush),
    .busy   (md_busy)
  );

  // Hazard detection: stall when a producer in E/M is not ready by the time D needs the value.
  always_comb begin
    stall_rs = (D_rs != 5'd0) && (D_tuse_rs != TUSE_NONE) &&
               (((D_rs == E_dst) && (E_tnew > D_tuse_rs)) ||
                ((D_rs == M_dst) && (M_tnew > D_tuse_rs)));
    stall_rt = (D_rt != 5'd0) && (D_tuse_rt != TUSE_NONE) &&
               (((D_rt == E_dst) && (E_tnew > D_tuse_rt)) ||
                ((D_rt == M_dst) && (M_tnew > D_tuse_rt)));
    stall_md = D_is_md && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    flush    = M_exc_req || M_eret;
  end

  // Priority mux: reset forcing, then flush, then stall, then normal flow.
  always_comb begin
    F_WE      = 1'b1;
    D_WE      = 1'b1;
    D_clr     = 1'b0;
    E_clr     = 1'b0;
    M_clr     = 1'b0;
    E_keep_pc = 1'b0;
    pc_sel    = PC_SEQ;
    if (!res) begin
      F_WE  = 1'b0;
      D_WE  = 1'b0;
      D_clr = 1'b1;
      E_clr = 1'b1;
      M_clr = 1'b1;
    end else if (flush) begin
      D_clr  = 1'b1;
      E_clr  = 1'b1;
      M_clr  = 1'b1;
      pc_sel = M_exc_req ? PC_EXC : PC_EPC;
    end else if (stall) begin
      F_WE      = 1'b0;
      D_WE      = 1'b0;
      E_clr     = 1'b1;
      E_keep_pc = 1'b1;
    end
  end

  // Stall counter next value: clear wins, otherwise saturating increment on real stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if (stall && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
